// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the mod_counter slice
package counter_pkg;

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} cnt_state_t;

   function automatic int unsigned clamp(input int unsigned val, input int unsigned max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/cnt_next.sv
// rtl/cnt_next.sv - combinational next-count and terminal detect for mod_counter
module cnt_next #(
   parameter int WIDTH = 4,
   parameter int MAX   = (1 << WIDTH) - 1
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   output logic [WIDTH-1:0] count_nxt,
   output logic             terminal
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   // Terminal is judged against MAX, so a short modulus wraps before the bit width does
   always_comb begin
      terminal  = up ? (count == MAX_V) : (count == ZERO_V);
      count_nxt = count;
      if (up) begin
         count_nxt = terminal ? ZERO_V : count + ONE_V;
      end else begin
         count_nxt = terminal ? MAX_V : count - ONE_V;
      end
   end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised synchronous up/down modulo counter with load and one-shot
module mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MAX     = (1 << WIDTH) - 1,
   parameter int ONESHOT = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   output logic [WIDTH-1:0] Count,
   output logic             Tc,
   output logic             Done
);

   if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
      $error("mod_counter: MAX out of range for WIDTH");
   end

   localparam bit IS_ONESHOT = (ONESHOT != 0);

   cnt_state_t       state_q, state_nxt;
   logic [WIDTH-1:0] count_q, count_d, step_val;
   logic             tc_q, tc_d, done_q, done_d;
   logic             terminal;
   logic             step_en;

   cnt_next #(.WIDTH(WIDTH), .MAX(MAX)) u_next (
      .count     (count_q),
      .up        (Up),
      .count_nxt (step_val),
      .terminal  (terminal)
   );

   assign step_en = En && (state_q == RUN);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RUN;
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         count_q <= count_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_nxt = state_q;
      if (Load) begin
         state_nxt = RUN;
      end else if (IS_ONESHOT && step_en && terminal) begin
         state_nxt = DONE;
      end
   end

   // In one-shot mode the terminal step holds Count instead of wrapping
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (Load) begin
         count_d = WIDTH'(clamp(32'(LoadVal), 32'(MAX)));
         done_d  = 1'b0;
      end else if (step_en) begin
         tc_d = terminal;
         if (IS_ONESHOT && terminal) begin
            done_d = 1'b1;
         end else begin
            count_d = step_val;
         end
      end
   end

   assign Count = count_q;
   assign Tc    = tc_q;
   assign Done  = done_q;

endmodule
